// File: rtl/sram_vec_reader.sv
// Strided SRAM read engine that streams a vector of elements out under valid/ready backpressure.
// Optional backpressure counter enabled by defining SRAM_VEC_READER_STALL_CNT_EN.
module sram_vec_reader #(
  parameter int unsigned SIZE       = 1024,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_LEN    = 64,
  localparam int unsigned AW        = $clog2(SIZE),
  localparam int unsigned LW        = $clog2(MAX_LEN + 1),
  localparam int unsigned IW        = $clog2(MAX_LEN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [AW-1:0]         req_base,
  input  logic [AW-1:0]         req_stride,
  input  logic [LW-1:0]         req_len,
  output logic [AW-1:0]         read_address,
  input  logic [DATA_WIDTH-1:0] sram_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [IW-1:0]         out_idx,
  output logic                  out_last,
  output logic                  done,
  output logic                  busy,
  output logic [31:0]           stall_cnt
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  localparam logic [LW-1:0] LenOne = LW'(1);

  logic [1:0]            state_q;
  logic [AW-1:0]         addr_q;
  logic [AW-1:0]         stride_q;
  logic [LW-1:0]         len_q;
  logic [LW-1:0]         issued_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [IW-1:0]         out_idx_q;
  logic                  out_last_q;
  logic                  done_q;

  logic accept;
  logic capture;
  logic is_last;

  always_comb begin
    accept  = req_valid && (state_q == StIdle);
    capture = (state_q == StRun) && (!out_valid_q || out_ready);
    is_last = (issued_q == (len_q - LenOne));
  end

  // The address register only advances on non-final captures, so it already
  // holds the final element's address throughout DRAIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      stride_q    <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            if (req_len != '0) begin
              addr_q   <= req_base;
              stride_q <= req_stride;
              len_q    <= req_len;
              issued_q <= '0;
              state_q  <= StRun;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        StRun: begin
          if (capture) begin
            out_data_q  <= sram_data;
            out_idx_q   <= issued_q[IW-1:0];
            out_last_q  <= is_last;
            out_valid_q <= 1'b1;
            issued_q    <= issued_q + LenOne;
            if (is_last) begin
              state_q <= StDrain;
            end else begin
              addr_q <= addr_q + stride_q;
            end
          end
        end
        StDrain: begin
          if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            state_q     <= StIdle;
            done_q      <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready    = (state_q == StIdle);
  assign busy         = (state_q != StIdle);
  assign read_address = addr_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_idx      = out_idx_q;
  assign out_last     = out_last_q;
  assign done         = done_q;

`ifdef SRAM_VEC_READER_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (accept) begin
      stall_cnt_q <= '0;
    end else if (out_valid_q && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_sram_vec_reader.sv
// Directed and randomized bench for sram_vec_reader with a queue-based expected-beat model.
module tb_sram_vec_reader;

  localparam int SIZE    = 1024;
  localparam int DW      = 8;
  localparam int MAX_LEN = 64;
  localparam int AW      = 10;
  localparam int LW      = 7;
  localparam int IW      = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_base;
  logic [AW-1:0] req_stride;
  logic [LW-1:0] req_len;
  logic [AW-1:0] read_address;
  logic [DW-1:0] sram_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          done;
  logic          busy;
  logic [31:0]   stall_cnt;

  logic [DW-1:0] mem [SIZE];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign sram_data = mem[read_address];

  sram_vec_reader #(
    .SIZE      (SIZE),
    .DATA_WIDTH(DW),
    .MAX_LEN   (MAX_LEN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_base    (req_base),
    .req_stride  (req_stride),
    .req_len     (req_len),
    .read_address(read_address),
    .sram_data   (sram_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_idx     (out_idx),
    .out_last    (out_last),
    .done        (done),
    .busy        (busy),
    .stall_cnt   (stall_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_stall(input int n);
`ifdef SRAM_VEC_READER_STALL_CNT_EN
    return 64'(n);
`else
    return 64'(n * 0);
`endif
  endfunction

  // Issue one request and follow the whole vector. Expected beats come from
  // address = (base + i*stride) mod SIZE and data = mem[address].
  task automatic do_vec(input int base, input int stride, input int len,
                        input int stall_beat, input int stall_n, input bit rnd,
                        input int rst_beat, input bit chain,
                        input int nb, input int ns, input int nl);
    int            addr[$];
    int            beat, seen, stalls, s, budget, sn;
    bit            stall_prev;
    logic [AW-1:0] prev_ra;
    for (int i = 0; i < len; i++) addr.push_back((base + i * stride) % SIZE);

    chk("req_ready_idle", 64'(req_ready), 64'd1);
    req_base   = AW'(base);
    req_stride = AW'(stride);
    req_len    = LW'(len);
    req_valid  = 1'b1;
    out_ready  = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);

    if (len == 0) begin
      chk("zl_done", 64'(done), 64'd1);
      chk("zl_valid", 64'(out_valid), 64'd0);
      chk("zl_busy", 64'(busy), 64'd0);
      chk("zl_ready", 64'(req_ready), 64'd1);
      @(negedge clk);
      chk("zl_done_once", 64'(done), 64'd0);
      chk("zl_valid2", 64'(out_valid), 64'd0);
      chk("zl_busy2", 64'(busy), 64'd0);
      return;
    end

    chk("start_done_low", 64'(done), 64'd0);
    chk("first_valid_low", 64'(out_valid), 64'd0);
    chk("first_addr", 64'(read_address), 64'(base % SIZE));
    chk("busy_run", 64'(busy), 64'd1);
    chk("req_ready_busy", 64'(req_ready), 64'd0);

    if (chain) begin
      req_base   = AW'(nb);
      req_stride = AW'(ns);
      req_len    = LW'(nl);
      req_valid  = 1'b1;
    end

    beat = 0; seen = -1; stalls = 0; s = 1; budget = 0; sn = 0;
    stall_prev = 1'b0;
    prev_ra = read_address;
    while (beat < len) begin
      @(negedge clk);
      s++;
      budget++;
      if (budget > 8 * len + 20) begin
        chk("timeout_beats", 64'(beat), 64'(len));
        break;
      end
      if (chain) chk("req_ready_held_low", 64'(req_ready), 64'd0);
      if (!out_valid) begin
        chk("last_without_valid", 64'(out_last), 64'd0);
      end else begin
        if (beat != seen) begin
          chk("capture_addr", 64'(prev_ra), 64'(addr[beat]));
          if (stalls == 0) chk("beat_timing", 64'(s), 64'(beat + 2));
          seen = beat;
        end
        if (stall_prev) chk("addr_held", 64'(read_address), 64'(prev_ra));
        chk("data", 64'(out_data), 64'(mem[addr[beat]]));
        chk("idx", 64'(out_idx), 64'(beat));
        chk("last", 64'(out_last), 64'(beat == len - 1));
        if (beat == rst_beat) begin
          rst = 1'b1;
          @(negedge clk);
          chk("rst_valid", 64'(out_valid), 64'd0);
          chk("rst_busy", 64'(busy), 64'd0);
          chk("rst_ready", 64'(req_ready), 64'd1);
          chk("rst_done", 64'(done), 64'd0);
          chk("rst_addr", 64'(read_address), 64'd0);
          chk("rst_last", 64'(out_last), 64'd0);
          chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
          rst = 1'b0;
          @(negedge clk);
          chk("rst_no_done", 64'(done), 64'd0);
          chk("rst_idle_valid", 64'(out_valid), 64'd0);
          out_ready = 1'b1;
          return;
        end
      end
      if (out_valid && beat == stall_beat && sn < stall_n) begin
        out_ready = 1'b0;
        sn++;
      end else if (rnd) begin
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        out_ready = 1'b1;
      end
      stall_prev = out_valid && !out_ready;
      if (stall_prev) stalls++;
      if (out_valid && out_ready) beat++;
      prev_ra = read_address;
    end

    out_ready = 1'b1;
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'd1);
    chk("done_req_ready", 64'(req_ready), 64'd1);
    chk("done_valid_low", 64'(out_valid), 64'd0);
    chk("done_busy_low", 64'(busy), 64'd0);
    chk("done_last_low", 64'(out_last), 64'd0);
    chk("stall_cnt", 64'(stall_cnt), exp_stall(stalls));
    if (!chain) begin
      @(negedge clk);
      chk("done_once", 64'(done), 64'd0);
    end
  endtask

  initial begin
    int b, st, ln;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_base   = '0;
    req_stride = '0;
    req_len    = '0;
    out_ready  = 1'b1;
    for (int i = 0; i < SIZE; i++) mem[i] = DW'(i & 8'hff);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_last", 64'(out_last), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_data", 64'(out_data), 64'd0);
    chk("reset_idx", 64'(out_idx), 64'd0);
    chk("reset_addr", 64'(read_address), 64'd0);
    chk("reset_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("reset_req_ready", 64'(req_ready), 64'd1);
    rst = 1'b0;
    @(negedge clk);

    // Basic sequential, wrap-around, backpressure, zero length.
    do_vec(10, 1, 4, -1, 0, 1'b0, -1, 1'b0, 0, 0, 0);
    do_vec(1020, 3, 3, -1, 0, 1'b0, -1, 1'b0, 0, 0, 0);
    do_vec(5, 2, 3, 1, 3, 1'b0, -1, 1'b0, 0, 0, 0);
    do_vec(7, 1, 0, -1, 0, 1'b0, -1, 1'b0, 0, 0, 0);

    // Request offered while busy, then taken right after completion.
    do_vec(100, 1, 5, -1, 0, 1'b0, -1, 1'b1, 200, 7, 6);
    do_vec(200, 7, 6, -1, 0, 1'b0, -1, 1'b0, 0, 0, 0);

    // Reset mid-vector, then a fresh request.
    do_vec(50, 1, 8, -1, 0, 1'b0, 2, 1'b0, 0, 0, 0);
    do_vec(60, 1, 3, -1, 0, 1'b0, -1, 1'b0, 0, 0, 0);

    for (int i = 0; i < SIZE; i++) mem[i] = DW'($urandom);
    do_vec(1000, 0, MAX_LEN, -1, 0, 1'b0, -1, 1'b0, 0, 0, 0);
    do_vec(3, 1023, MAX_LEN, -1, 0, 1'b1, -1, 1'b0, 0, 0, 0);
    for (int k = 0; k < 20; k++) begin
      b  = int'($urandom_range(0, SIZE - 1));
      st = int'($urandom_range(0, SIZE - 1));
      ln = int'($urandom_range(0, MAX_LEN));
      do_vec(b, st, ln, -1, 0, 1'b1, -1, 1'b0, 0, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
